// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative data cache: FSM encoding and
// address-field width helpers.
package cache_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StFetch,
        StUpdate
    } state_e;

    function automatic int unsigned off_width(input int unsigned block_bytes);
        return $clog2(block_bytes);
    endfunction

    function automatic int unsigned idx_width(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned sets,
                                              input int unsigned block_bytes);
        return addr_w - idx_width(sets) - off_width(block_bytes);
    endfunction

    // Storage widths must not collapse to zero for single-set / single-way builds.
    function automatic int unsigned at_least_one(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/lru_tracker.sv
// True-LRU age tracker: one age per way per set, kept as a permutation with
// age 0 = most recently used. The victim is the way holding the oldest age.
module lru_tracker
    import cache_pkg::*;
#(
    parameter int unsigned Ways = 2,
    parameter int unsigned Sets = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [at_least_one($clog2(Sets))-1:0] set_i,
    input  logic                                  access_en_i,
    input  logic [at_least_one($clog2(Ways))-1:0] access_way_i,
    output logic [at_least_one($clog2(Ways))-1:0] victim_o
);

    localparam int unsigned AgeW = at_least_one($clog2(Ways));

    logic [AgeW-1:0] age_q [Sets][Ways];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < Sets; s++) begin
                for (int unsigned w = 0; w < Ways; w++) begin
                    age_q[s][w] <= AgeW'(w);
                end
            end
        end else if (access_en_i) begin
            // Ways younger than the accessed one age by one; the accessed way becomes MRU.
            for (int unsigned w = 0; w < Ways; w++) begin
                if (AgeW'(w) == access_way_i) begin
                    age_q[set_i][w] <= '0;
                end else if (age_q[set_i][w] < age_q[set_i][access_way_i]) begin
                    age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        victim_o = '0;
        for (int unsigned w = 0; w < Ways; w++) begin
            if (age_q[set_i][w] == AgeW'(Ways - 1)) begin
                victim_o = AgeW'(w);
            end
        end
    end

endmodule

// File: rtl/assoc_dcache.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement and saturating hit/miss counters; BUSYWAIT handshake on both sides.
module assoc_dcache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SETS        = 4,
    parameter int unsigned WAYS        = 2,
    parameter int unsigned BLOCK_BYTES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                                       CLK,
    input  logic                                       RESET,
    input  logic                                       CPU_READ,
    input  logic                                       CPU_WRITE,
    input  logic [ADDR_W-1:0]                          CPU_ADDRESS,
    input  logic [7:0]                                 CPU_WRITEDATA,
    output logic [7:0]                                 CPU_READDATA,
    output logic                                       CPU_BUSYWAIT,
    output logic                                       MEM_READ,
    output logic                                       MEM_WRITE,
    output logic [ADDR_W-off_width(BLOCK_BYTES)-1:0]   MEM_ADDRESS,
    output logic [8*BLOCK_BYTES-1:0]                   MEM_WRITEDATA,
    input  logic [8*BLOCK_BYTES-1:0]                   MEM_READDATA,
    input  logic                                       MEM_BUSYWAIT,
    output logic [CNT_W-1:0]                           HIT_COUNT,
    output logic [CNT_W-1:0]                           MISS_COUNT
);

    localparam int unsigned OFF_W   = off_width(BLOCK_BYTES);
    localparam int unsigned IDX_W   = idx_width(SETS);
    localparam int unsigned TAG_W   = tag_width(ADDR_W, SETS, BLOCK_BYTES);
    localparam int unsigned IDX_S   = at_least_one(IDX_W);
    localparam int unsigned WAY_W   = at_least_one($clog2(WAYS));
    localparam int unsigned BLK_W   = 8 * BLOCK_BYTES;
    localparam int unsigned MADDR_W = ADDR_W - OFF_W;

    function automatic logic [MADDR_W-1:0] blk_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_S-1:0] idx);
        return (MADDR_W'(tag) << IDX_W) | MADDR_W'(idx);
    endfunction

    state_e              state_q;
    logic                valid_q [SETS][WAYS];
    logic                dirty_q [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [BLK_W-1:0]    data_q  [SETS][WAYS];
    logic [WAY_W-1:0]    victim_q;
    logic [7:0]          readdata_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [MADDR_W-1:0]  mem_addr_q;
    logic [BLK_W-1:0]    mem_wdata_q;
    logic [CNT_W-1:0]    hit_cnt_q;
    logic [CNT_W-1:0]    miss_cnt_q;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_S-1:0]    req_idx;
    logic [OFF_W-1:0]    req_off;
    logic                req;
    logic                in_idle;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic                inv_found;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    lru_victim;
    logic [WAY_W-1:0]    victim_way;
    logic [BLK_W-1:0]    hit_block;
    logic [7:0]          hit_byte;
    logic                idle_hit;
    logic                idle_miss;
    logic                rd_hit;
    logic                wr_hit;

    assign req_tag = TAG_W'(CPU_ADDRESS >> (IDX_W + OFF_W));
    assign req_idx = IDX_S'((CPU_ADDRESS >> OFF_W) & ADDR_W'(SETS - 1));
    assign req_off = CPU_ADDRESS[OFF_W-1:0];

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign hit_block  = data_q[req_idx][hit_way];
    assign hit_byte   = hit_block[{req_off, 3'b000} +: 8];
    assign victim_way = inv_found ? inv_way : lru_victim;

    // Everything that acts on the CPU side is gated by RESET so reset silences outputs.
    assign req       = CPU_READ | CPU_WRITE;
    assign in_idle   = (state_q == StIdle);
    assign idle_hit  = RESET && in_idle && req && hit;
    assign idle_miss = RESET && in_idle && req && !hit;
    assign wr_hit    = idle_hit && CPU_WRITE;
    assign rd_hit    = idle_hit && !CPU_WRITE;

    assign CPU_BUSYWAIT  = RESET && (!in_idle || (req && !hit));
    assign CPU_READDATA  = rd_hit ? hit_byte : readdata_q;
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;
    assign HIT_COUNT     = hit_cnt_q;
    assign MISS_COUNT    = miss_cnt_q;

    lru_tracker #(
        .Ways (WAYS),
        .Sets (SETS)
    ) u_lru (
        .clk_i        (CLK),
        .rst_ni       (RESET),
        .set_i        (req_idx),
        .access_en_i  (idle_hit),
        .access_way_i (hit_way),
        .victim_o     (lru_victim)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= StIdle;
            victim_q    <= '0;
            readdata_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (idle_hit) begin
                        hit_cnt_q <= (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + 1'b1;
                        if (wr_hit) begin
                            dirty_q[req_idx][hit_way] <= 1'b1;
                        end else begin
                            readdata_q <= hit_byte;
                        end
                    end else if (idle_miss) begin
                        miss_cnt_q <= (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
                        victim_q   <= victim_way;
                        if (dirty_q[req_idx][victim_way]) begin
                            state_q     <= StWriteback;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= blk_addr(tag_q[req_idx][victim_way], req_idx);
                            mem_wdata_q <= data_q[req_idx][victim_way];
                        end else begin
                            state_q    <= StFetch;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= blk_addr(req_tag, req_idx);
                        end
                    end
                end
                StWriteback: begin
                    if (!MEM_BUSYWAIT) begin
                        state_q     <= StFetch;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= blk_addr(req_tag, req_idx);
                    end
                end
                StFetch: begin
                    if (!MEM_BUSYWAIT) begin
                        state_q    <= StUpdate;
                        mem_read_q <= 1'b0;
                    end
                end
                StUpdate: begin
                    state_q                    <= StIdle;
                    valid_q[req_idx][victim_q] <= 1'b1;
                    dirty_q[req_idx][victim_q] <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tags and data need no reset: valid bits guard them.
    always_ff @(posedge CLK) begin
        if (wr_hit) begin
            data_q[req_idx][hit_way][{req_off, 3'b000} +: 8] <= CPU_WRITEDATA;
        end
        if (RESET && state_q == StUpdate) begin
            data_q[req_idx][victim_q] <= MEM_READDATA;
            tag_q[req_idx][victim_q]  <= req_tag;
        end
    end

endmodule

// File: doc/assoc_dcache.md
Name: assoc_dcache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache with LRU replacement.
- Successor to the direct-mapped data cache. Sits between the CPU load/store port and the data memory, using the same BUSYWAIT handshake on both sides.
- Adds configurable sets, ways and block size, true LRU victim selection, and saturating hit/miss counters for performance profiling in the CPU bench.

Parameters:
- ADDR_W, 8, CPU byte-address width.
- SETS, 4, number of sets; power of 2, at least 1.
- WAYS, 2, associativity; power of 2, at least 1.
- BLOCK_BYTES, 4, bytes per block; power of 2, at least 2.
- CNT_W, 16, width of the hit and miss counters.
- Derived: OFF_W = log2(BLOCK_BYTES); IDX_W = log2(SETS); TAG_W = ADDR_W - IDX_W - OFF_W, which must be at least 1.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge CLK).
- CPU_READ  in  1  load request; held until CPU_BUSYWAIT is low.
- CPU_WRITE  in  1  store request; held until CPU_BUSYWAIT is low.
- CPU_ADDRESS  in  ADDR_W  byte address.
- CPU_WRITEDATA  in  8  store byte.
- CPU_READDATA  out  8  load byte.
- CPU_BUSYWAIT  out  1  stall to CPU.
- MEM_READ  out  1  block read request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  ADDR_W-OFF_W  block address.
- MEM_WRITEDATA  out  8*BLOCK_BYTES  victim block.
- MEM_READDATA  in  8*BLOCK_BYTES  fill block.
- MEM_BUSYWAIT  in  1  memory busy. Memory raises it combinationally in the request cycle and lowers it when data or write is done.
- HIT_COUNT  out  CNT_W  saturating hit counter.
- MISS_COUNT  out  CNT_W  saturating miss counter.

Behaviour:
- Address split: tag = ADDR[ADDR_W-1 : IDX_W+OFF_W], index = ADDR[IDX_W+OFF_W-1 : OFF_W], offset = ADDR[OFF_W-1 : 0].
- Per way, per set: valid bit, dirty bit, tag, data block. Per set: LRU age of log2(WAYS) bits per way, kept as a permutation of 0..WAYS-1; age 0 means MRU.
- Reset (RESET==0 at posedge): all valid=0, dirty=0; ages of way i set to i; state IDLE; counters 0. Outputs during and after reset: CPU_BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, CPU_READDATA=0.
- Reset while in any state, including mid-fill or mid-writeback: abandon the transaction, drop MEM_READ/MEM_WRITE the next cycle, and lose any dirty data.
- Request is CPU_READ | CPU_WRITE. If both are high, the request is a write and the read is ignored.
- Hit (some valid way whose tag matches, in IDLE):
  - CPU_BUSYWAIT=0 combinationally.
  - Read: CPU_READDATA = hit byte, combinationally.
  - Write: byte written and dirty set at the next posedge.
  - At that posedge: hit way becomes age 0; ways younger than its old age are incremented; HIT_COUNT += 1 (saturates at all-ones).
  - Back-to-back hits complete one per cycle.
- Miss (in IDLE): CPU_BUSYWAIT=1 combinationally. At the posedge, MISS_COUNT += 1 (saturating) and the victim is chosen:
  - the lowest-index invalid way, else
  - the way with age WAYS-1.
  - Victim dirty: go to WRITEBACK; otherwise go to FETCH.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS = {victim tag, index}, MEM_WRITEDATA = victim block. Move to FETCH on the first posedge where MEM_BUSYWAIT==0 (after at least one cycle in the state).
  - FETCH: MEM_READ=1, MEM_ADDRESS = {request tag, index}. Move to UPDATE at the first posedge where MEM_BUSYWAIT==0 (after at least one cycle).
  - UPDATE, one cycle: at the posedge, install MEM_READDATA, set tag, valid=1, dirty=0; then return to IDLE.
- Back in IDLE the request hits normally. It is not counted as a second miss, but it is counted as a hit. CPU_BUSYWAIT stays 1 from the miss cycle through UPDATE.
- A miss costs 1 + (writeback cycles) + (fetch cycles) + 1 cycles of stall. In IDLE with no request: CPU_BUSYWAIT=0 and no memory request.
- Memory outputs are registered by state. Only one of MEM_READ/MEM_WRITE is ever high.
- CPU_READDATA holds its last value when there is no read hit.

Decomposition:
- Package cache_pkg: state encoding (IDLE, WRITEBACK, FETCH, UPDATE) and width-derivation functions (clog2-based OFF_W, IDX_W, TAG_W).
- Sub-module lru_tracker: parametrised by WAYS. Holds the per-set age vectors; inputs are access-way, access-enable and set index; outputs are the victim way. Also performs the reset permutation.

Test Plan:
- Cold read miss: reset, read 0x05 with memory block 0x01 = 0x44332211. Expect CPU_BUSYWAIT=1, MEM_READ with MEM_ADDRESS=0x01, then CPU_READDATA=0x22, MISS_COUNT=1, HIT_COUNT=1. Re-read 0x05: no stall, HIT_COUNT=2.
- Clean eviction (set 0): write 0x00=0xAB, read 0x10, read 0x00, read 0x20. Expect the 0x20 fill to evict way holding tag 1 (clean) with MEM_WRITE never asserted; MISS_COUNT=3.
- Dirty eviction: continue with read 0x10. Expect MEM_WRITE with MEM_ADDRESS=0x00 and MEM_WRITEDATA[7:0]=0xAB, followed by MEM_READ with MEM_ADDRESS=0x04, then data from block 0x04 returned.
- Reset mid-fill: assert RESET=0 while in FETCH. Expect MEM_READ=0 the next cycle and CPU_BUSYWAIT=0. A subsequent read of the same address misses again, and the counters restart from 0.
- Simultaneous request: CPU_READ=CPU_WRITE=1 to cached 0x05 with data 0x77. Expect the write to be performed; a later read of 0x05 returns 0x77.
- Throughput: 8 consecutive read hits within one block. Expect CPU_BUSYWAIT=0 on every cycle, HIT_COUNT incremented by 8, and no memory requests.
